// File: rtl/dmem_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : Data-memory access sequencer for the MEMORY stage. Turns a
//                load/store into a held bus request, stalls the pipeline
//                until the bus answers (ack, err or timeout), and captures
//                load data for the WRITEBACK stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  ByteEnM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        StallMem,
    output logic        FlushW,
    output logic [31:0] ReadDataM,
    output logic        AccessFault
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value seen in the last permitted BUS cycle.
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;

    logic w_access;
    logic w_timeout;
    logic w_finish;
    logic w_fault;
    logic w_capture;

    // Decode of access start, bus completion and fault conditions.
    always_comb begin
        w_access  = MemReadM | MemWriteM;
        w_timeout = (r_cnt == c_cnt_last);
        w_finish  = bus_ack | bus_err | w_timeout;
        // err beats ack; ack in the timeout cycle beats the timeout.
        w_fault   = bus_err | (w_timeout & ~bus_ack);
        w_capture = bus_ack & ~bus_err & ~bus_we;
    end

    // Stall covers the detection cycle in IDLE and every BUS cycle.
    always_comb begin
        StallMem = ((r_state == ST_IDLE) && w_access) || (r_state == ST_BUS);
        FlushW   = StallMem;
    end

    // Access FSM with registered bus-side outputs, load data and fault pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 32'd0;
            bus_be      <= 4'd0;
            ReadDataM   <= 32'd0;
            AccessFault <= 1'b0;
        end else begin
            AccessFault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        // Read+write together is handled as a write.
                        bus_we    <= MemWriteM;
                        bus_addr  <= ALUResultM;
                        bus_wdata <= WriteDataM;
                        bus_be    <= MemWriteM ? ByteEnM : 4'b1111;
                        bus_req   <= 1'b1;
                        r_cnt     <= 8'd0;
                        r_state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_finish) begin
                        bus_req     <= 1'b0;
                        AccessFault <= w_fault;
                        r_state     <= ST_DONE;
                        if (w_capture) begin
                            ReadDataM <= bus_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    // The instruction still in MEMORY is not re-detected.
                    r_state <= ST_IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 16, meaning the number of BUS-state cycles without ack/err before an access is aborted; legal range 1..255.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 MemReadM  input  1  load instruction present in MEMORY stage.
REQ-005 MemWriteM  input  1  store instruction present in MEMORY stage.
REQ-006 ALUResultM  input  32  byte address of the access.
REQ-007 WriteDataM  input  32  store data.
REQ-008 ByteEnM  input  4  store byte lanes.
REQ-009 bus_req  output  1  bus request, held until ack/err/timeout.
REQ-010 bus_we  output  1  1 = write, 0 = read.
REQ-011 bus_addr  output  32  registered address.
REQ-012 bus_wdata  output  32  registered store data.
REQ-013 bus_be  output  4  registered byte lanes; 4'b1111 for reads.
REQ-014 bus_ack  input  1  access complete; bus_rdata valid this cycle for reads.
REQ-015 bus_err  input  1  access failed.
REQ-016 bus_rdata  input  32  read data.
REQ-017 StallMem  output  1  freezes FETCH, DECODE, EXECUTE, MEMORY pipeline registers; ORed with StallF/StallD outside.
REQ-018 FlushW  output  1  inserts bubble into WRITEBACK register.
REQ-019 ReadDataM  output  32  captured load data, valid in DONE.
REQ-020 AccessFault  output  1  one-cycle pulse on bus_err or timeout.

Function
REQ-021 The block SHALL implement states IDLE, BUS, DONE.
REQ-022 IDLE: access = MemReadM|MemWriteM; if access, StallMem=1 combinationally in that cycle, latch address/data/lanes/we into bus registers, next state BUS; else stay IDLE, StallMem=0.
REQ-023 MemReadM and MemWriteM both high SHALL be treated as a write (bus_we=1).
REQ-024 BUS: bus_req=1, StallMem=1; bus registers SHALL stay constant while bus_req=1.
REQ-025 BUS with bus_ack=1: capture bus_rdata into ReadDataM (reads only; writes leave ReadDataM unchanged), next state DONE.
REQ-026 BUS with bus_err=1: next state DONE, AccessFault=1 for the following cycle; err wins over simultaneous ack; ReadDataM unchanged.
REQ-027 An 8-bit cycle counter SHALL clear on BUS entry and increment each BUS cycle; at TIMEOUT cycles in BUS without ack/err, abort as for bus_err; ack/err in the timeout cycle takes precedence over timeout.
REQ-028 DONE: bus_req=0, StallMem=0, pipeline advances; next state IDLE unconditionally (no re-detection of the instruction still in MEMORY).
REQ-029 FlushW SHALL equal StallMem in every cycle.
REQ-030 bus_ack/bus_err SHALL be ignored in IDLE and DONE.
REQ-031 Minimum latency: access detected cycle N, bus_req at N+1, ack at N+1 gives DONE at N+2; 2 stall cycles per access.
REQ-032 Back-to-back accesses SHALL pass through IDLE between them (at least one IDLE cycle after DONE).

Reset
REQ-033 reset_n=0 SHALL asynchronously force state IDLE, counter 0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, ReadDataM=0, AccessFault=0; StallMem/FlushW follow IDLE decode of inputs.
REQ-034 Reset asserted mid-BUS SHALL drop bus_req in the same cycle without waiting for ack.

Verification
REQ-035 Load addr 0x100, ack one cycle after bus_req with rdata 0xDEADBEEF -> StallMem high 2 cycles, ReadDataM=0xDEADBEEF in DONE, AccessFault=0.
REQ-036 Store addr 0x204, data 0x12345678, be 4'b0011, ack after 5 cycles -> bus_we=1, bus signals stable 5 cycles, StallMem high 6 cycles.
REQ-037 TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, AccessFault pulse 1 cycle, StallMem drops in DONE.
REQ-038 bus_ack and bus_err same cycle on load -> AccessFault=1, ReadDataM unchanged.
REQ-039 Two consecutive loads -> IDLE cycle between DONE and second bus_req, both data captured correctly.
REQ-040 reset_n low during BUS -> bus_req=0 immediately, state IDLE, outputs at reset values after release.
